// File: rtl/rename_pkg.sv
// Shared types and widths for the rename stage: decoded/renamed instruction
// records, commit records and RAT entries.
package rename_pkg;

  localparam int unsigned PRF_ENTRIES  = 64;
  localparam int unsigned ARF_ENTRIES  = 32;
  localparam int unsigned COMMIT_PORTS = 1;

  localparam int unsigned PREG_ID_BITS = $clog2(PRF_ENTRIES);
  localparam int unsigned AREG_ID_BITS = $clog2(ARF_ENTRIES);
  localparam int unsigned ID_BITS      = 8;

  typedef logic [PREG_ID_BITS-1:0] preg_id_t;
  typedef logic [AREG_ID_BITS-1:0] areg_id_t;
  typedef logic [ID_BITS-1:0]      seq_id_t;
  typedef logic [PREG_ID_BITS:0]   fl_count_t;

  typedef enum logic [1:0] {FU_ALU, FU_MUL, FU_LSU, FU_BRU} fu_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    fu_t         fu;
    logic [3:0]  op;
    areg_id_t    rd;
    areg_id_t    rs1;
    areg_id_t    rs2;
    logic        rd_valid;
    logic        rs1_valid;
    logic        rs2_valid;
  } si_t;

  typedef struct packed {
    seq_id_t  id;
    preg_id_t prd;
    preg_id_t prs1;
    preg_id_t prs2;
    logic     prs1_renammed;
    logic     prs2_renammed;
    si_t      si;
  } di_t;

  typedef struct packed {
    areg_id_t rd;
    preg_id_t prd;
    logic     rd_valid;
  } commit_t;

  typedef struct packed {
    preg_id_t preg;
    logic     renamed;
  } rat_entry_t;

  // x0 is hardwired, so only a valid non-zero register takes part in renaming.
  function automatic logic writes_areg(input logic valid, input areg_id_t r);
    return valid && (r != '0);
  endfunction

endpackage

// File: rtl/rename_freelist.sv
// Circular free list of physical registers: one pop, NR_COMMIT_PORTS pushes
// per cycle. Reset and flush both reload the identity contents 0..PRFSIZE-1.
module rename_freelist
  import rename_pkg::*;
#(
  parameter int unsigned PRFSIZE         = PRF_ENTRIES,
  parameter int unsigned NR_COMMIT_PORTS = COMMIT_PORTS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       pop,
  input  logic [NR_COMMIT_PORTS-1:0] push,
  input  preg_id_t                   push_preg [NR_COMMIT_PORTS],
  output preg_id_t                   head_preg,
  output fl_count_t                  count,
  output logic                       empty
);

  preg_id_t           mem [PRFSIZE];
  preg_id_t           head;
  preg_id_t           tail;
  preg_id_t           push_idx [NR_COMMIT_PORTS];
  fl_count_t          n_push;
  logic [PRFSIZE-1:0] is_free;

  assign head_preg = mem[head];
  assign empty     = (count == '0);

  // Pushes land in port order, each slot offset by the earlier valid pushes.
  always_comb begin
    n_push = '0;
    for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
      push_idx[p] = tail + n_push[PREG_ID_BITS-1:0];
      n_push      = n_push + fl_count_t'(push[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < PRFSIZE; i++) mem[i] <= preg_id_t'(i);
      head    <= '0;
      tail    <= '0;
      count   <= fl_count_t'(PRFSIZE);
      is_free <= '1;
    end else begin
      if (pop) begin
        head             <= head + preg_id_t'(1);
        is_free[head_preg] <= 1'b0;
      end
      for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
        if (push[p]) begin
          assert (!is_free[push_preg[p]]);
          mem[push_idx[p]]      <= push_preg[p];
          is_free[push_preg[p]] <= 1'b1;
        end
      end
      tail  <= tail + n_push[PREG_ID_BITS-1:0];
      count <= count - fl_count_t'(pop) + n_push;
    end
  end

endmodule

// File: rtl/rename.sv
// Rename stage: allocates physical destinations from the free list, looks up
// sources in the RAT, tags each instruction with a sequence id, retires on commit.
module rename
  import rename_pkg::*;
#(
  parameter int unsigned PRFSIZE         = PRF_ENTRIES,
  parameter int unsigned ARFSIZE         = ARF_ENTRIES,
  parameter int unsigned NR_COMMIT_PORTS = COMMIT_PORTS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  si_t                        si_i,
  input  logic                       si_i_valid,
  output logic                       si_i_ready,
  output di_t                        di_o,
  output logic                       di_o_valid,
  input  logic                       di_o_ready,
  input  commit_t                    commit_i [NR_COMMIT_PORTS],
  input  logic [NR_COMMIT_PORTS-1:0] commit_i_valid,
  input  logic                       flush_i
);

  rat_entry_t                 rat [ARFSIZE];
  seq_id_t                    seq;
  logic                       needs_alloc;
  logic                       accept;
  logic                       alloc;
  logic                       fl_empty;
  preg_id_t                   fl_head;
  fl_count_t                  fl_count;
  logic [NR_COMMIT_PORTS-1:0] push;
  preg_id_t                   push_preg [NR_COMMIT_PORTS];
  di_t                        di_next;

  assign needs_alloc = writes_areg(si_i.rd_valid, si_i.rd);
  assign si_i_ready  = !flush_i && (!di_o_valid || di_o_ready) && (!needs_alloc || !fl_empty);
  assign accept      = si_i_valid && si_i_ready;
  assign alloc       = accept && needs_alloc;

  always_comb begin
    for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
      push[p]      = commit_i_valid[p] && writes_areg(commit_i[p].rd_valid, commit_i[p].rd);
      push_preg[p] = commit_i[p].prd;
    end
  end

  rename_freelist #(
    .PRFSIZE         (PRFSIZE),
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS)
  ) u_freelist (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .pop       (alloc),
    .push      (push),
    .push_preg (push_preg),
    .head_preg (fl_head),
    .count     (fl_count),
    .empty     (fl_empty)
  );

  // Sources read the RAT as it stood before this instruction's own update.
  always_comb begin
    di_next               = '0;
    di_next.id            = seq;
    di_next.prd           = needs_alloc ? fl_head : '0;
    di_next.prs1          = rat[si_i.rs1].preg;
    di_next.prs2          = rat[si_i.rs2].preg;
    di_next.prs1_renammed = rat[si_i.rs1].renamed && writes_areg(si_i.rs1_valid, si_i.rs1);
    di_next.prs2_renammed = rat[si_i.rs2].renamed && writes_areg(si_i.rs2_valid, si_i.rs2);
    di_next.si            = si_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      di_o       <= '0;
      di_o_valid <= 1'b0;
      seq        <= '0;
      for (int unsigned i = 0; i < ARFSIZE; i++) rat[i] <= '0;
    end else if (flush_i) begin
      di_o_valid <= 1'b0;
      for (int unsigned i = 0; i < ARFSIZE; i++) rat[i].renamed <= 1'b0;
    end else begin
      assert (fl_count <= fl_count_t'(PRFSIZE));
      for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
        if (push[p] && rat[commit_i[p].rd].preg == commit_i[p].prd)
          rat[commit_i[p].rd].renamed <= 1'b0;
      end
      // Written after the commit loop so a same-cycle rename of rd wins.
      if (alloc) rat[si_i.rd] <= '{preg: fl_head, renamed: 1'b1};
      if (accept) begin
        di_o       <= di_next;
        di_o_valid <= 1'b1;
        seq        <= seq + seq_id_t'(1);
      end else if (di_o_ready) begin
        di_o_valid <= 1'b0;
      end
    end
  end

  assert property (@(posedge clk)
    (!rst && !flush_i && di_o_valid && !di_o_ready) |=> $stable(di_o));

endmodule

// File: tb/tb_rename.sv
// Self-checking bench for rename: a reference model feeds a scoreboard of
// expected di_o records; scenario tasks add targeted checks.
module tb_rename;
  import rename_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  si_t                     si_i;
  logic                    si_i_valid;
  logic                    si_i_ready;
  di_t                     di_o;
  logic                    di_o_valid;
  logic                    di_o_ready;
  commit_t                 commit_i [COMMIT_PORTS];
  logic [COMMIT_PORTS-1:0] commit_i_valid;
  logic                    flush_i;

  rename #(
    .PRFSIZE         (PRF_ENTRIES),
    .ARFSIZE         (ARF_ENTRIES),
    .NR_COMMIT_PORTS (COMMIT_PORTS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .si_i           (si_i),
    .si_i_valid     (si_i_valid),
    .si_i_ready     (si_i_ready),
    .di_o           (di_o),
    .di_o_valid     (di_o_valid),
    .di_o_ready     (di_o_ready),
    .commit_i       (commit_i),
    .commit_i_valid (commit_i_valid),
    .flush_i        (flush_i)
  );

  int       n_checks = 0;
  int       n_fail   = 0;
  di_t      sb [$];
  di_t      mon_exp;
  di_t      last_exp;
  logic     out_new = 1'b0;

  preg_id_t m_fl [$];
  preg_id_t m_preg [ARF_ENTRIES];
  logic     m_ren [ARF_ENTRIES];
  seq_id_t  m_seq;
  logic     m_valid;

  function automatic si_t mk(input int rd, input int rs1, input int rs2,
                             input logic rdv, input logic r1v, input logic r2v);
    si_t s;
    s           = '0;
    s.rd        = areg_id_t'(rd);
    s.rs1       = areg_id_t'(rs1);
    s.rs2       = areg_id_t'(rs2);
    s.rd_valid  = rdv;
    s.rs1_valid = r1v;
    s.rs2_valid = r2v;
    s.pc        = $urandom;
    s.imm       = $urandom;
    s.op        = 4'($urandom_range(0, 15));
    s.fu        = fu_t'($urandom_range(0, 3));
    return s;
  endfunction

  function automatic commit_t mkc(input int rd, input int prd);
    commit_t c;
    c.rd       = areg_id_t'(rd);
    c.prd      = preg_id_t'(prd);
    c.rd_valid = 1'b1;
    return c;
  endfunction

  task automatic m_reset(input logic full);
    m_fl.delete();
    for (int i = 0; i < PRF_ENTRIES; i++) m_fl.push_back(preg_id_t'(i));
    for (int i = 0; i < ARF_ENTRIES; i++) begin
      m_ren[i] = 1'b0;
      if (full) m_preg[i] = '0;
    end
    m_valid = 1'b0;
    if (full) m_seq = '0;
  endtask

  // Advance one cycle, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic acc;
    logic na;
    di_t  e;
    e   = '0;
    na  = si_i.rd_valid && si_i.rd != '0;
    acc = si_i_valid && !rst && !flush_i && (!m_valid || di_o_ready) && (!na || m_fl.size() != 0);
    if (rst) begin
      m_reset(1'b1);
    end else if (flush_i) begin
      m_reset(1'b0);
    end else begin
      if (acc) begin
        e.id            = m_seq;
        e.si            = si_i;
        e.prs1          = m_preg[si_i.rs1];
        e.prs2          = m_preg[si_i.rs2];
        e.prs1_renammed = m_ren[si_i.rs1] && si_i.rs1_valid && si_i.rs1 != '0;
        e.prs2_renammed = m_ren[si_i.rs2] && si_i.rs2_valid && si_i.rs2 != '0;
        if (na) e.prd = m_fl.pop_front();
        sb.push_back(e);
        last_exp = e;
        m_seq++;
      end
      for (int p = 0; p < COMMIT_PORTS; p++) begin
        if (commit_i_valid[p] && commit_i[p].rd_valid && commit_i[p].rd != '0) begin
          m_fl.push_back(commit_i[p].prd);
          if (m_preg[commit_i[p].rd] == commit_i[p].prd) m_ren[commit_i[p].rd] = 1'b0;
        end
      end
      if (acc && na) begin
        m_preg[si_i.rd] = e.prd;
        m_ren[si_i.rd]  = 1'b1;
      end
      if (acc) m_valid = 1'b1;
      else if (di_o_ready) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    out_new = acc;
  endtask

  always @(negedge clk) begin
    if (out_new) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got output id=%0d, expected no output", di_o.id);
      end else begin
        mon_exp = sb.pop_front();
        if (di_o_valid !== 1'b1 || di_o !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_di_o: got valid=%b id=%0d prd=%0d prs1=%0d/%b prs2=%0d/%b, expected valid=1 id=%0d prd=%0d prs1=%0d/%b prs2=%0d/%b",
                   di_o_valid, di_o.id, di_o.prd, di_o.prs1, di_o.prs1_renammed, di_o.prs2, di_o.prs2_renammed,
                   mon_exp.id, mon_exp.prd, mon_exp.prs1, mon_exp.prs1_renammed, mon_exp.prs2, mon_exp.prs2_renammed);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; si_i = '0; si_i_valid = 1'b0; di_o_ready = 1'b1;
    commit_i[0] = '0; commit_i_valid = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (di_o_valid !== 1'b0 || di_o !== '0) begin
      n_fail++; $display("FAIL reset_di_o: got valid=%b di=%h, expected 0", di_o_valid, di_o);
    end
    n_checks++;
    if (dut.fl_count !== 7'd64) begin
      n_fail++; $display("FAIL reset_count: got %0d, expected 64", dut.fl_count);
    end
    n_checks++;
    if (si_i_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b, expected 1", si_i_ready);
    end
  endtask

  task automatic test_dependent();
    si_i = mk(5, 0, 0, 1'b1, 1'b1, 1'b0); si_i_valid = 1'b1;
    tick();
    n_checks++;
    if (di_o_valid !== 1'b1 || di_o.prd !== 6'd0 || di_o.prs1_renammed !== 1'b0 || di_o.id !== 8'd0) begin
      n_fail++; $display("FAIL addi_x5: got valid=%b prd=%0d ren1=%b id=%0d, expected 1 0 0 0",
                         di_o_valid, di_o.prd, di_o.prs1_renammed, di_o.id);
    end
    n_checks++;
    if (dut.rat[5].preg !== 6'd0 || dut.rat[5].renamed !== 1'b1 || dut.fl_count !== 7'd63) begin
      n_fail++; $display("FAIL rat5_after_addi: got preg=%0d ren=%b count=%0d, expected 0 1 63",
                         dut.rat[5].preg, dut.rat[5].renamed, dut.fl_count);
    end
    si_i = mk(6, 5, 5, 1'b1, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (di_o.prs1 !== 6'd0 || di_o.prs2 !== 6'd0 || di_o.prs1_renammed !== 1'b1 ||
        di_o.prs2_renammed !== 1'b1 || di_o.prd !== 6'd1 || di_o.id !== 8'd1) begin
      n_fail++; $display("FAIL add_x6_x5_x5: got prs=%0d/%0d ren=%b%b prd=%0d id=%0d, expected 0/0 11 1 1",
                         di_o.prs1, di_o.prs2, di_o.prs1_renammed, di_o.prs2_renammed, di_o.prd, di_o.id);
    end
    si_i_valid = 1'b0;
    tick();
  endtask

  task automatic test_commit_collision();
    commit_i[0] = mkc(5, 0); commit_i_valid = 1'b1;
    tick();
    commit_i_valid = 1'b0;
    n_checks++;
    if (dut.rat[5].renamed !== 1'b0) begin
      n_fail++; $display("FAIL commit_clears_x5: got renamed=%b, expected 0", dut.rat[5].renamed);
    end
    si_i = mk(0, 5, 0, 1'b0, 1'b1, 1'b0); si_i_valid = 1'b1;
    tick();
    n_checks++;
    if (di_o.prs1_renammed !== 1'b0 || di_o.prd !== 6'd0) begin
      n_fail++; $display("FAIL read_x5_arf: got ren1=%b prd=%0d, expected 0 0", di_o.prs1_renammed, di_o.prd);
    end
    si_i = mk(5, 0, 0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int r = 10; r < 14; r++) begin
      si_i = mk(r, r - 1, 0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    si_i = mk(5, 0, 0, 1'b1, 1'b0, 1'b0);
    commit_i[0] = mkc(5, 2); commit_i_valid = 1'b1;
    tick();
    commit_i_valid = 1'b0;
    n_checks++;
    if (dut.rat[5].preg !== 6'd7 || dut.rat[5].renamed !== 1'b1 || di_o.prd !== 6'd7) begin
      n_fail++; $display("FAIL rename_wins: got preg=%0d ren=%b prd=%0d, expected 7 1 7",
                         dut.rat[5].preg, dut.rat[5].renamed, di_o.prd);
    end
    si_i = mk(8, 5, 0, 1'b1, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (di_o.prs1 !== 6'd7 || di_o.prs1_renammed !== 1'b1) begin
      n_fail++; $display("FAIL read_x5_prf: got prs1=%0d ren=%b, expected 7 1", di_o.prs1, di_o.prs1_renammed);
    end
    si_i_valid = 1'b0;
    tick();
  endtask

  task automatic test_exhaust();
    int k;
    k = 0;
    si_i_valid = 1'b1;
    while (m_fl.size() != 0) begin
      si_i = mk(1 + (k % 31), k % 32, (k + 3) % 32, 1'b1, 1'b1, 1'b1);
      k++;
      tick();
    end
    n_checks++;
    if (dut.fl_count !== 7'd0) begin
      n_fail++; $display("FAIL count_exhausted: got %0d, expected 0", dut.fl_count);
    end
    si_i = mk(9, 1, 2, 1'b1, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (si_i_ready !== 1'b0) begin
      n_fail++; $display("FAIL empty_stall: got ready=%b, expected 0", si_i_ready);
    end
    tick();
    si_i = mk(0, 1, 2, 1'b0, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (si_i_ready !== 1'b1) begin
      n_fail++; $display("FAIL store_when_empty: got ready=%b, expected 1", si_i_ready);
    end
    tick();
    si_i = mk(9, 1, 2, 1'b1, 1'b1, 1'b1);
    commit_i[0] = mkc(1, 3); commit_i_valid = 1'b1;
    #1;
    n_checks++;
    if (si_i_ready !== 1'b0) begin
      n_fail++; $display("FAIL no_bypass: got ready=%b, expected 0", si_i_ready);
    end
    tick();
    commit_i_valid = 1'b0;
    #1;
    n_checks++;
    if (si_i_ready !== 1'b1) begin
      n_fail++; $display("FAIL resume_ready: got ready=%b, expected 1", si_i_ready);
    end
    tick();
    n_checks++;
    if (di_o.prd !== 6'd3) begin
      n_fail++; $display("FAIL resume_prd: got %0d, expected 3", di_o.prd);
    end
    si_i_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    si_i_valid = 1'b0;
    for (int p = 20; p < 30; p++) begin
      commit_i[0] = mkc(1, p); commit_i_valid = 1'b1;
      tick();
    end
    commit_i_valid = 1'b0;
    di_o_ready = 1'b0;
    si_i = mk(12, 5, 6, 1'b1, 1'b1, 1'b1); si_i_valid = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (si_i_ready !== 1'b0 || di_o_valid !== 1'b1 || di_o !== last_exp ||
          dut.fl_count !== fl_count_t'(m_fl.size())) begin
        n_fail++; $display("FAIL stall_hold: got ready=%b valid=%b id=%0d count=%0d, expected 0 1 %0d %0d",
                           si_i_ready, di_o_valid, di_o.id, dut.fl_count, last_exp.id, m_fl.size());
      end
      tick();
    end
    di_o_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      si_i = mk(13 + c, 12 + c, 0, 1'b1, 1'b1, 1'b0);
      #1;
      n_checks++;
      if (si_i_ready !== 1'b1) begin
        n_fail++; $display("FAIL release_ready: got %b, expected 1", si_i_ready);
      end
      tick();
    end
    si_i_valid = 1'b0;
    tick();
    n_checks++;
    if (dut.fl_count !== fl_count_t'(m_fl.size())) begin
      n_fail++; $display("FAIL release_count: got %0d, expected %0d", dut.fl_count, m_fl.size());
    end
  endtask

  task automatic test_flush();
    logic [ARF_ENTRIES-1:0] ren_bits;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    si_i_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      si_i = mk(1 + k, k, k + 2, 1'b1, 1'b1, 1'b1);
      tick();
    end
    si_i_valid = 1'b0;
    flush_i = 1'b1;
    commit_i[0] = mkc(1, 0); commit_i_valid = 1'b1;
    tick();
    flush_i = 1'b0;
    commit_i_valid = 1'b0;
    for (int i = 0; i < ARF_ENTRIES; i++) ren_bits[i] = dut.rat[i].renamed;
    n_checks++;
    if (di_o_valid !== 1'b0 || dut.fl_count !== 7'd64 || ren_bits !== '0) begin
      n_fail++; $display("FAIL flush_state: got valid=%b count=%0d renamed=%h, expected 0 64 0",
                         di_o_valid, dut.fl_count, ren_bits);
    end
    si_i = mk(3, 1, 0, 1'b1, 1'b1, 1'b0); si_i_valid = 1'b1;
    tick();
    n_checks++;
    if (di_o.id !== 8'd10 || di_o.prd !== 6'd0 || di_o.prs1_renammed !== 1'b0) begin
      n_fail++; $display("FAIL flush_id_continues: got id=%0d prd=%0d ren1=%b, expected 10 0 0",
                         di_o.id, di_o.prd, di_o.prs1_renammed);
    end
    si_i_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_dependent();
    test_commit_collision();
    test_exhaust();
    test_stall();
    test_flush();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
